// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - req/gnt memory bus with one-cycle response
interface mem_bus_arbiter_if #(
    parameter int AW = 64,
    parameter int SW = 8,
    parameter int DW = 64
);
    logic          req;
    logic          wen;
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (
        output req, wen, addr, strb, wdata,
        input  gnt, err, rdata
    );

    modport slave (
        input  req, wen, addr, strb, wdata,
        output gnt, err, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - imem/dmem to single memory port arbiter
module mem_bus_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_STRB_W = 8,
    parameter int MEM_DATA_W = 64,
    parameter int MAX_STARVE = 4
) (
    input  logic                    g_clk,
    input  logic                    g_reset,
    mem_bus_arbiter_if.slave        imem,
    mem_bus_arbiter_if.slave        dmem,
    mem_bus_arbiter_if.master       mem,
    output logic [1:0]              arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_I      = 2'b01;
    localparam logic [1:0] OWN_D      = 2'b10;
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    state_e                 state_q, state_d;
    logic [1:0]             rsp_owner_q, rsp_owner_d;
    logic [3:0]             starve_q, starve_d;
    logic [1:0]             sel;
    logic                   sel_req;
    logic                   sel_wen;
    logic [MEM_ADDR_W-1:0]  sel_addr;
    logic [MEM_STRB_W-1:0]  sel_strb;
    logic [MEM_DATA_W-1:0]  sel_wdata;
    logic                   i_grant;
    logic                   d_grant;

    // A locked port keeps the downstream payload stable until it is granted
    always_comb begin
        sel = OWN_NONE;
        case (state_q)
            ST_LOCK_I: sel = OWN_I;
            ST_LOCK_D: sel = OWN_D;
            default: begin
                if (imem.req && dmem.req)
                    sel = (starve_q == STARVE_MAX) ? OWN_I : OWN_D;
                else if (imem.req)
                    sel = OWN_I;
                else if (dmem.req)
                    sel = OWN_D;
            end
        endcase
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_strb  = '0;
        sel_wdata = '0;
        case (sel)
            OWN_I: begin
                sel_req   = imem.req;
                sel_wen   = imem.wen;
                sel_addr  = imem.addr;
                sel_strb  = imem.strb;
                sel_wdata = imem.wdata;
            end
            OWN_D: begin
                sel_req   = dmem.req;
                sel_wen   = dmem.wen;
                sel_addr  = dmem.addr;
                sel_strb  = dmem.strb;
                sel_wdata = dmem.wdata;
            end
            default: ;
        endcase
    end

    assign mem.req   = sel_req;
    assign mem.wen   = sel_wen;
    assign mem.addr  = sel_addr;
    assign mem.strb  = sel_strb;
    assign mem.wdata = sel_wdata;
    assign arb_owner = sel;

    assign imem.gnt = mem.gnt && (sel == OWN_I);
    assign dmem.gnt = mem.gnt && (sel == OWN_D);
    assign i_grant  = sel_req && mem.gnt && (sel == OWN_I);
    assign d_grant  = sel_req && mem.gnt && (sel == OWN_D);

    assign imem.err   = mem.err && (rsp_owner_q == OWN_I);
    assign dmem.err   = mem.err && (rsp_owner_q == OWN_D);
    assign imem.rdata = mem.rdata;
    assign dmem.rdata = mem.rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_req && !mem.gnt)
                    state_d = (sel == OWN_I) ? ST_LOCK_I : ST_LOCK_D;
            end
            ST_LOCK_I: if (mem.gnt || !imem.req) state_d = ST_IDLE;
            ST_LOCK_D: if (mem.gnt || !dmem.req) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_owner_d = (sel_req && mem.gnt) ? sel : OWN_NONE;
        starve_d    = starve_q;
        if (i_grant)
            starve_d = 4'd0;
        else if (d_grant && imem.req)
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            rsp_owner_q <= OWN_NONE;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            rsp_owner_q <= rsp_owner_d;
            starve_q    <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int MAX_STARVE = 4;

    logic       g_clk = 1'b0;
    logic       g_reset;
    logic [1:0] arb_owner;

    mem_bus_arbiter_if #(.AW(64), .SW(8), .DW(64)) imem_bus ();
    mem_bus_arbiter_if #(.AW(64), .SW(8), .DW(64)) dmem_bus ();
    mem_bus_arbiter_if #(.AW(64), .SW(8), .DW(64)) mem_bus ();

    mem_bus_arbiter #(
        .MEM_ADDR_W (64),
        .MEM_STRB_W (8),
        .MEM_DATA_W (64),
        .MAX_STARVE (MAX_STARVE)
    ) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .imem      (imem_bus),
        .dmem      (dmem_bus),
        .mem       (mem_bus),
        .arb_owner (arb_owner)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: 0 none, 1 imem, 2 dmem
    int   m_lock;
    int   m_starve;
    int   m_rsp;
    logic last_ig, last_dg;
    int   grant_log[$];
    int   starve_peak;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_lock   = 0;
        m_starve = 0;
        m_rsp    = 0;
    endtask

    function automatic int model_sel(input logic ireq, input logic dreq);
        if (m_lock != 0) return m_lock;
        if (ireq && dreq) return (m_starve == MAX_STARVE) ? 1 : 2;
        if (ireq) return 1;
        if (dreq) return 2;
        return 0;
    endfunction

    task automatic set_idle();
        imem_bus.req = 0; imem_bus.wen = 0; imem_bus.addr = '0; imem_bus.strb = '0; imem_bus.wdata = '0;
        dmem_bus.req = 0; dmem_bus.wen = 0; dmem_bus.addr = '0; dmem_bus.strb = '0; dmem_bus.wdata = '0;
        mem_bus.gnt = 0; mem_bus.err = 0; mem_bus.rdata = '0;
    endtask

    task automatic rand_payload(input int port);
        logic [63:0] a, w;
        a = {$urandom, $urandom};
        w = {$urandom, $urandom};
        if (port == 1) begin
            imem_bus.addr = a; imem_bus.wdata = w;
            imem_bus.strb = 8'($urandom); imem_bus.wen = 1'($urandom);
        end else begin
            dmem_bus.addr = a; dmem_bus.wdata = w;
            dmem_bus.strb = 8'($urandom); dmem_bus.wen = 1'($urandom);
        end
    endtask

    // One clock: check outputs at negedge against the model, advance the model, re-arm at posedge+1
    task automatic step();
        int   sel;
        logic ireq, dreq, exp_mreq, granted;
        @(negedge g_clk);
        ireq     = imem_bus.req;
        dreq     = dmem_bus.req;
        sel      = model_sel(ireq, dreq);
        exp_mreq = (sel == 1) ? ireq : (sel == 2) ? dreq : 1'b0;
        check_eq("mem_req",    64'(mem_bus.req),   64'(exp_mreq));
        check_eq("arb_owner",  64'(arb_owner),     64'(sel));
        check_eq("imem_gnt",   64'(imem_bus.gnt),  64'(mem_bus.gnt && sel == 1));
        check_eq("dmem_gnt",   64'(dmem_bus.gnt),  64'(mem_bus.gnt && sel == 2));
        check_eq("imem_err",   64'(imem_bus.err),  64'(mem_bus.err && m_rsp == 1));
        check_eq("dmem_err",   64'(dmem_bus.err),  64'(mem_bus.err && m_rsp == 2));
        check_eq("imem_rdata", imem_bus.rdata,     mem_bus.rdata);
        check_eq("dmem_rdata", dmem_bus.rdata,     mem_bus.rdata);
        check_eq("starve_ctr", 64'(dut.starve_q),  64'(m_starve));
        if (sel == 1) begin
            check_eq("mem_addr",  mem_bus.addr,  imem_bus.addr);
            check_eq("mem_wdata", mem_bus.wdata, imem_bus.wdata);
            check_eq("mem_ctl",   64'({mem_bus.wen, mem_bus.strb}), 64'({imem_bus.wen, imem_bus.strb}));
        end else if (sel == 2) begin
            check_eq("mem_addr",  mem_bus.addr,  dmem_bus.addr);
            check_eq("mem_wdata", mem_bus.wdata, dmem_bus.wdata);
            check_eq("mem_ctl",   64'({mem_bus.wen, mem_bus.strb}), 64'({dmem_bus.wen, dmem_bus.strb}));
        end
        if (int'(dut.starve_q) > starve_peak) starve_peak = int'(dut.starve_q);
        last_ig = imem_bus.gnt;
        last_dg = dmem_bus.gnt;

        granted = exp_mreq && mem_bus.gnt;
        m_rsp   = granted ? sel : 0;
        if (granted) grant_log.push_back(sel);
        if (granted && sel == 1) m_starve = 0;
        else if (granted && sel == 2 && ireq && m_starve < MAX_STARVE) m_starve++;
        if (m_lock != 0) begin
            if (mem_bus.gnt || !((m_lock == 1) ? ireq : dreq)) m_lock = 0;
        end else if (exp_mreq && !mem_bus.gnt) begin
            m_lock = sel;
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        g_reset = 1;
        set_idle();
        model_reset();
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        g_reset = 0;
    endtask

    initial begin
        int exp_order[10];
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        last_ig = 0; last_dg = 0; starve_peak = 0;

        // Reset state with no requests
        g_reset = 1;
        set_idle();
        model_reset();
        #2;
        check_eq("rst_owner",    64'(arb_owner),                 64'd0);
        check_eq("rst_req_gnt",  64'({mem_bus.req, imem_bus.gnt, dmem_bus.gnt}), 64'd0);
        check_eq("rst_err",      64'({imem_bus.err, dmem_bus.err}), 64'd0);
        @(posedge g_clk); #1;
        g_reset = 0;

        // Single imem grant then error response
        imem_bus.req = 1; imem_bus.addr = 64'h1000; mem_bus.gnt = 1;
        #1;
        check_eq("t1_addr",  mem_bus.addr,        64'h1000);
        check_eq("t1_gnt",   64'(imem_bus.gnt),   64'd1);
        check_eq("t1_owner", 64'(arb_owner),      64'd1);
        step();
        imem_bus.req = 0; mem_bus.gnt = 0; mem_bus.err = 1;
        #1;
        check_eq("t1_ierr", 64'(imem_bus.err), 64'd1);
        check_eq("t1_derr", 64'(dmem_bus.err), 64'd0);
        step();

        // Starvation order with both requesting every cycle
        do_reset();
        grant_log.delete();
        starve_peak = 0;
        imem_bus.req = 1; imem_bus.addr = 64'hA000;
        dmem_bus.req = 1; dmem_bus.addr = 64'hD000;
        mem_bus.gnt = 1;
        for (int i = 0; i < 10; i++) step();
        check_eq("t2_len", 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check_eq($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
        check_eq("t2_peak", 64'(starve_peak), 64'(MAX_STARVE));

        // imem locked while dmem arrives
        do_reset();
        imem_bus.req = 1; imem_bus.addr = 64'h2222; mem_bus.gnt = 0;
        step();
        dmem_bus.req = 1; dmem_bus.addr = 64'h3333;
        step();
        check_eq("t3_owner", 64'(arb_owner), 64'd1);
        check_eq("t3_addr",  mem_bus.addr,   64'h2222);
        step();
        mem_bus.gnt = 1;
        #1;
        check_eq("t3_igrant", 64'(imem_bus.gnt), 64'd1);
        check_eq("t3_dwait",  64'(dmem_bus.gnt), 64'd0);
        step();
        imem_bus.req = 0;
        #1;
        check_eq("t3_dgrant", 64'(dmem_bus.gnt), 64'd1);
        step();

        // Alternating I,D,I with error on the D response only
        do_reset();
        mem_bus.gnt = 1;
        imem_bus.req = 1; step();
        imem_bus.req = 0; dmem_bus.req = 1; step();
        dmem_bus.req = 0; imem_bus.req = 1; mem_bus.err = 1;
        #1;
        check_eq("t4_derr", 64'(dmem_bus.err), 64'd1);
        check_eq("t4_ierr", 64'(imem_bus.err), 64'd0);
        step();
        imem_bus.req = 0; mem_bus.err = 0; step();
        mem_bus.err = 1;
        #1;
        check_eq("t4_ierr_q", 64'(imem_bus.err), 64'd0);
        step();

        // Async reset between dmem grant and its response
        do_reset();
        imem_bus.req = 1; dmem_bus.req = 1; mem_bus.gnt = 1;
        step();
        imem_bus.req = 0; dmem_bus.req = 0; mem_bus.gnt = 0; mem_bus.err = 1;
        #1;
        check_eq("t5_pre_derr", 64'(dmem_bus.err), 64'd1);
        g_reset = 1;
        #1;
        check_eq("t5_derr",   64'(dmem_bus.err),  64'd0);
        check_eq("t5_owner",  64'(arb_owner),     64'd0);
        check_eq("t5_starve", 64'(dut.starve_q),  64'd0);
        check_eq("t5_state",  64'(dut.state_q),   64'd0);
        model_reset();
        @(posedge g_clk); #1;
        g_reset = 0;
        mem_bus.err = 0;

        // Locked dmem drops its request
        dmem_bus.req = 1; dmem_bus.addr = 64'h4444; mem_bus.gnt = 0;
        step();
        dmem_bus.req = 0; imem_bus.req = 1; imem_bus.addr = 64'h5555; mem_bus.gnt = 1;
        #1;
        check_eq("t6_nogrant", 64'({imem_bus.gnt & imem_bus.req, dmem_bus.gnt & dmem_bus.req, mem_bus.req}), 64'd0);
        step();
        #1;
        check_eq("t6_owner", 64'(arb_owner),     64'd1);
        check_eq("t6_igrant", 64'(imem_bus.gnt), 64'd1);
        step();

        // Randomized protocol-compliant traffic
        do_reset();
        last_ig = 0; last_dg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!(imem_bus.req && !last_ig && $urandom_range(0, 49) != 0)) begin
                imem_bus.req = ($urandom_range(0, 2) != 0);
                rand_payload(1);
            end
            if (!(dmem_bus.req && !last_dg && $urandom_range(0, 49) != 0)) begin
                dmem_bus.req = ($urandom_range(0, 2) != 0);
                rand_payload(2);
            end
            mem_bus.gnt   = ($urandom_range(0, 3) != 0);
            mem_bus.err   = 1'($urandom_range(0, 1));
            mem_bus.rdata = {$urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
